scmp_sin_tx: RTL and testbench

- 8N1 async serial transmitter. Drives the SC/MP `sin` pin so the CPU can receive bytes via SIO/E-register shifting.
- Sits in the board top beside the CPU, clocked from the PLL 1 MHz output.
- Has a one-byte holding register plus a shift register, so a host-side source (debug loader, test stimulus) can stream bytes back-to-back with no idle gap between frames.

---
 rtl/scmp_sin_tx_pkg.sv | 21 ++
 rtl/scmp_sin_tx_if.sv | 13 +
 rtl/scmp_sin_tx_baud_div.sv | 31 +++
 rtl/scmp_sin_tx.sv | 137 +++++++++++++
 tb/tb_scmp_sin_tx.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/scmp_sin_tx_pkg.sv
// scmp_uart_pkg: shared types and helpers for the SC/MP serial blocks.
//   tx_state_t : transmitter FSM states
//   DATA_BITS  : data bits per frame
//   calc_div   : rounded clock-cycles-per-bit for a clock/baud pair
package scmp_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int unsigned DATA_BITS = 8;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + (baud / 2)) / baud;
    endfunction

endpackage

// File: rtl/scmp_sin_tx_if.sv
// scmp_sin_tx_if: byte source -> transmitter handshake.
//   tx_data  : byte to send, sampled on accept
//   tx_valid : source has a byte on tx_data
//   tx_ready : transmitter holding register empty
// Accept = tx_valid & tx_ready at a rising clk_1m edge.
interface scmp_sin_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/scmp_sin_tx_baud_div.sv
// uart_baud_div: loadable bit-period down-counter.
//   clk_1m : clock, rising edge
//   rst_n  : asynchronous active-low reset (count cleared)
//   load   : reload count with DIV-1 at the next edge (wins over counting)
//   tick   : count == 0, i.e. last cycle of the current bit period
// Holds at zero when not reloaded.
module uart_baud_div #(
    parameter int unsigned DIV = 104
) (
    input  logic clk_1m,
    input  logic rst_n,
    input  logic load,
    output logic tick
);
    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(DIV - 1);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/scmp_sin_tx.sv
// scmp_sin_tx: 8N1 (or 8N2) async serial transmitter driving the SC/MP sin pin.
//   clk_1m : 1 MHz clock, rising edge
//   rst_n  : asynchronous active-low reset; aborts any frame at once
//   tx     : byte handshake (slave side: tx_data, tx_valid in; tx_ready out)
//   tx_out : registered serial line, IDLE_LEVEL when idle
//   busy   : frame in progress or holding register full
// A one-byte holding register in front of the shifter lets frames run
// back-to-back: at the end of the stop bit a held byte goes straight to START.
module scmp_sin_tx
    import scmp_uart_pkg::*;
#(
    parameter int unsigned BIT_DIV    = 104,
    parameter int unsigned STOP_BITS  = 1,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic              clk_1m,
    input  logic              rst_n,
    scmp_sin_tx_if.slave      tx,
    output logic              tx_out,
    output logic              busy
);
    localparam int unsigned IW = $clog2(DATA_BITS);

    tx_state_t         state, state_n;
    logic [7:0]        shift, shift_n;
    logic [7:0]        hold_data, hold_data_n;
    logic [IW-1:0]     bit_idx, bit_idx_n;
    logic              stop_cnt, stop_cnt_n;
    logic              tx_ready_q, tx_ready_n;
    logic              tx_out_n;
    logic              baud_load;
    logic              tick;
    logic              accept;

    uart_baud_div #(.DIV(BIT_DIV)) u_baud (
        .clk_1m (clk_1m),
        .rst_n  (rst_n),
        .load   (baud_load),
        .tick   (tick)
    );

    assign accept      = tx.tx_valid & tx_ready_q;
    assign tx.tx_ready = tx_ready_q;
    assign busy        = (state != IDLE) | ~tx_ready_q;

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift      <= '0;
            hold_data  <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_out     <= IDLE_LEVEL;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            hold_data  <= hold_data_n;
            bit_idx    <= bit_idx_n;
            stop_cnt   <= stop_cnt_n;
            tx_ready_q <= tx_ready_n;
            tx_out     <= tx_out_n;
        end
    end

    always_comb begin
        state_n     = state;
        shift_n     = shift;
        hold_data_n = hold_data;
        bit_idx_n   = bit_idx;
        stop_cnt_n  = stop_cnt;
        tx_ready_n  = tx_ready_q;
        baud_load   = 1'b0;

        // A shifter load (needs hold full) and an accept (needs hold empty)
        // are mutually exclusive, so both may update tx_ready_n below.
        unique case (state)
            IDLE: begin
                if (!tx_ready_q) begin
                    shift_n    = hold_data;
                    tx_ready_n = 1'b1;
                    baud_load  = 1'b1;
                    state_n    = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_idx_n = '0;
                    baud_load = 1'b1;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n   = shift >> 1;
                    baud_load = 1'b1;
                    if (bit_idx == IW'(DATA_BITS - 1)) begin
                        stop_cnt_n = 1'b0;
                        state_n    = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if ((STOP_BITS == 2) && !stop_cnt) begin
                        stop_cnt_n = 1'b1;
                        baud_load  = 1'b1;
                    end else if (!tx_ready_q) begin
                        shift_n    = hold_data;
                        tx_ready_n = 1'b1;
                        baud_load  = 1'b1;
                        state_n    = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (accept) begin
            hold_data_n = tx.tx_data;
            tx_ready_n  = 1'b0;
        end

        // Line level is registered from the next state so it changes on the
        // same edge the state does.
        unique case (state_n)
            START:   tx_out_n = ~IDLE_LEVEL;
            DATA:    tx_out_n = shift_n[0] ^ ~IDLE_LEVEL;
            default: tx_out_n = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_scmp_sin_tx.sv
// tb_scmp_sin_tx: directed bench for scmp_sin_tx.
// Three instances: 0 = BIT_DIV 4 / 1 stop, 1 = BIT_DIV 4 / 2 stops,
// 2 = BIT_DIV 104 / 1 stop. Accepted bytes go into a scoreboard queue; the
// frame checker takes the expected byte from it, compares tx_out every cycle
// against the frame model and decodes mid-bit samples for a byte compare.
`timescale 1ns/1ps
module tb_scmp_sin_tx;

    logic clk_1m = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_1m = ~clk_1m;

    scmp_sin_tx_if if0 ();
    scmp_sin_tx_if if1 ();
    scmp_sin_tx_if if2 ();

    logic [7:0] d_data  [3];
    logic       d_valid [3];
    logic       txo [3];
    logic       bsy [3];
    logic       rdy [3];

    assign if0.tx_data  = d_data[0];
    assign if0.tx_valid = d_valid[0];
    assign if1.tx_data  = d_data[1];
    assign if1.tx_valid = d_valid[1];
    assign if2.tx_data  = d_data[2];
    assign if2.tx_valid = d_valid[2];
    assign rdy[0] = if0.tx_ready;
    assign rdy[1] = if1.tx_ready;
    assign rdy[2] = if2.tx_ready;

    scmp_sin_tx #(.BIT_DIV(4), .STOP_BITS(1), .IDLE_LEVEL(1'b1)) dut0 (
        .clk_1m (clk_1m), .rst_n (rst_n), .tx (if0), .tx_out (txo[0]), .busy (bsy[0]));
    scmp_sin_tx #(.BIT_DIV(4), .STOP_BITS(2), .IDLE_LEVEL(1'b1)) dut1 (
        .clk_1m (clk_1m), .rst_n (rst_n), .tx (if1), .tx_out (txo[1]), .busy (bsy[1]));
    scmp_sin_tx #(.BIT_DIV(104), .STOP_BITS(1), .IDLE_LEVEL(1'b1)) dut2 (
        .clk_1m (clk_1m), .rst_n (rst_n), .tx (if2), .tx_out (txo[2]), .busy (bsy[2]));

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  sbq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_1m);
        #1;
    endtask

    // One clock for instance s; a handshake that completes on this edge is
    // recorded in the scoreboard.
    task automatic step_s(input int s, input bit keep);
        bit acc;
        acc = d_valid[s] && rdy[s];
        step();
        if (acc) begin
            sbq.push_back(d_data[s]);
            if (!keep) d_valid[s] = 1'b0;
        end
    endtask

    // Returns just after the accepting edge.
    task automatic accept(input int s, input logic [7:0] b, input bit keep);
        int unsigned t;
        t = 0;
        d_data[s]  = b;
        d_valid[s] = 1'b1;
        while (!rdy[s] && t < 200) begin
            step_s(s, 1'b1);
            t++;
        end
        chk("accept_wait", 32'(t < 200), 1);
        step_s(s, keep);
    endtask

    // Called in the first cycle of a start bit; checks nframes contiguous frames.
    task automatic check_frames(input int s, input int unsigned div,
                                input int unsigned sb, input int unsigned nframes);
        for (int unsigned f = 0; f < nframes; f++) begin
            logic [7:0]  eb, dec, got;
            int unsigned start_w;
            bit          in_start;
            logic        lvl;
            chk("sb_depth", 32'(sbq.size() != 0), 1);
            if (sbq.size() == 0) return;
            eb = sbq[0];
            dec = '0;
            start_w = 0;
            in_start = 1'b1;
            for (int unsigned c = 0; c < (9 + sb) * div; c++) begin
                int unsigned bi;
                bi = c / div;
                if (bi == 0)      lvl = 1'b0;
                else if (bi <= 8) lvl = eb[bi-1];
                else              lvl = 1'b1;
                chk("tx_out", 32'(txo[s]), 32'(lvl));
                chk("busy_frame", 32'(bsy[s]), 1);
                if (c == 0) chk("ready_at_start", 32'(rdy[s]), 1);
                if (in_start && txo[s] == 1'b0) start_w++;
                else in_start = 1'b0;
                if (bi >= 1 && bi <= 8 && (c % div) == div / 2) dec[bi-1] = txo[s];
                step_s(s, 1'b0);
            end
            got = sbq.pop_front();
            chk("decoded", 32'(dec), 32'(got));
            if (eb[0]) chk("start_width", start_w, div);
        end
        chk("idle_line", 32'(txo[s]), 1);
        chk("busy_end", 32'(bsy[s]), 0);
        chk("ready_end", 32'(rdy[s]), 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            d_data[i]  = '0;
            d_valid[i] = 1'b0;
        end

        // Reset and idle
        repeat (3) step();
        #4 rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("rst_tx_out", 32'(txo[i]), 1);
            chk("rst_ready", 32'(rdy[i]), 1);
            chk("rst_busy", 32'(bsy[i]), 0);
        end
        for (int c = 0; c < 50; c++) begin
            for (int i = 0; i < 3; i++) begin
                chk("idle_tx_out", 32'(txo[i]), 1);
                chk("idle_ready", 32'(rdy[i]), 1);
                chk("idle_busy", 32'(bsy[i]), 0);
            end
            step();
        end

        // Single byte 0x55
        accept(0, 8'h55, 1'b0);
        chk("acc_ready_low", 32'(rdy[0]), 0);
        chk("acc_busy", 32'(bsy[0]), 1);
        chk("acc_latency_line", 32'(txo[0]), 1);
        step_s(0, 1'b0);
        check_frames(0, 4, 1, 1);

        // Back-to-back 0xA5, 0x3C with tx_valid held
        accept(0, 8'hA5, 1'b1);
        d_data[0] = 8'h3C;
        chk("b2b_ready_low", 32'(rdy[0]), 0);
        step_s(0, 1'b0);
        check_frames(0, 4, 1, 2);

        // Two stop bits: 0xFF then 0x00 contiguous
        accept(1, 8'hFF, 1'b1);
        d_data[1] = 8'h00;
        step_s(1, 1'b0);
        check_frames(1, 4, 2, 2);

        // Reset during data bit 3 of 0x00
        accept(0, 8'h00, 1'b0);
        step_s(0, 1'b0);
        repeat (17) step_s(0, 1'b0);
        chk("pre_rst_line", 32'(txo[0]), 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_line", 32'(txo[0]), 1);
        chk("async_rst_ready", 32'(rdy[0]), 1);
        chk("async_rst_busy", 32'(bsy[0]), 0);
        sbq.delete();
        #3 rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            chk("post_rst_line", 32'(txo[0]), 1);
            chk("post_rst_busy", 32'(bsy[0]), 0);
        end
        chk("post_rst_ready", 32'(rdy[0]), 1);

        // Full-rate divider: 0x0D
        accept(2, 8'h0D, 1'b0);
        step_s(2, 1'b0);
        check_frames(2, 104, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
